// File: rtl/boot_pkg.sv
//==============================================================================
// Module      : boot_pkg
// Description : Shared types and constants for the UART boot loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package boot_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 2-FF synchronizer and glitch rejection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err
);

    localparam int                c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    rx_state_t            r_state, w_state_nxt;
    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]           r_bit, w_bit_nxt;
    logic [7:0]           r_shift, w_shift_nxt;
    logic                 r_valid, w_valid;
    logic                 r_ferr, w_ferr;
    logic                 w_line;
    logic                 w_fall;

    assign w_line = r_sync[1];
    // Edge-triggered start: after a low stop bit the line must rise before re-arming.
    assign w_fall = r_prev & ~w_line;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx_in};
            r_prev  <= w_line;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid     = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_cnt == c_half) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = w_line ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (r_cnt == c_full) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_line, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_full) begin
                    w_cnt_nxt   = '0;
                    w_valid     = w_line;
                    w_ferr      = ~w_line;
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_valid     = r_valid;
    assign rx_byte      = r_shift;
    assign rx_frame_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader.sv
//==============================================================================
// Module      : uart_boot_loader
// Description : Loads a UART program image into instruction memory, then
//               releases the core from reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int IMEM_DEPTH   = 256
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    output logic        frame_err
);

    boot_state_t r_state, w_state_nxt;
    logic        w_rx_valid;
    logic [7:0]  w_rx_byte;
    logic        w_rx_ferr;
    logic [15:0] r_n;
    logic [15:0] r_word;
    logic [15:0] w_n_hdr;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_cpu_rst;
    logic        r_frame_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (uart_rx),
        .rx_valid     (w_rx_valid),
        .rx_byte      (w_rx_byte),
        .rx_frame_err (w_rx_ferr)
    );

    assign w_n_hdr = {w_rx_byte, r_n[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR_LO: if (w_rx_valid) w_state_nxt = HDR_HI;
            HDR_HI: begin
                if (w_rx_valid) begin
                    if (w_n_hdr == 16'd0)
                        w_state_nxt = DONE;
                    else if ({16'd0, w_n_hdr} > 32'(IMEM_DEPTH))
                        w_state_nxt = ERR;
                    else
                        w_state_nxt = DATA;
                end
            end
            // Leave DATA only once the final strobe cycle has been presented.
            DATA:    if (r_we && ((r_word + 16'd1) == r_n)) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            ERR:     w_state_nxt = ERR;
            default: w_state_nxt = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HDR_LO;
            r_n         <= '0;
            r_word      <= '0;
            r_byte_idx  <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_rst <= (w_state_nxt != DONE);
            r_we      <= 1'b0;
            if (w_rx_ferr) r_frame_err <= 1'b1;
            if (w_rx_valid) begin
                case (r_state)
                    HDR_LO: r_n[7:0]  <= w_rx_byte;
                    HDR_HI: r_n[15:8] <= w_rx_byte;
                    DATA: begin
                        r_wdata[8*r_byte_idx +: 8] <= w_rx_byte;
                        r_byte_idx                 <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) r_we <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (r_we) r_word <= r_word + 16'd1;
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = 32'(r_word) * 32'(BYTES_PER_WORD);
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign load_done  = (r_state == DONE);
    assign load_err   = (r_state == ERR);
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: doc/uart_boot_loader.md
# uart_boot_loader

Upstream loader for the multi-cycle RISC-V core. It receives a program image over a UART RX line and assembles little-endian bytes into 32-bit instructions. It writes those instructions sequentially into the instruction memory write port. The core is held in reset until the whole image has been written, then released so it fetches from address 0.

## Interface
- `CLKS_PER_BIT`, default 87: clk cycles per UART bit (8N1); must be ≥ 4.
- `IMEM_DEPTH`, default 256: instruction memory size in 32-bit words; must be ≤ 65535.
- `clk`  in  1  core clock (divided clock domain); single clock for the block.
- `rst`  in  1  reset, asynchronous, active-low.
- `uart_rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `imem_we`  out  1  one-cycle write strobe to instruction memory.
- `imem_addr`  out  32  byte address of the write (word index × 4).
- `imem_wdata`  out  32  instruction word.
- `cpu_rst`  out  1  active-high reset to the core; high until the load completes.
- `load_done`  out  1  sticky; image fully written.
- `load_err`  out  1  sticky; header word count exceeded `IMEM_DEPTH`.
- `frame_err`  out  1  sticky; a stop bit sampled low.

## Operation
- Image format: 2-byte header, word count N (LSB first), followed by 4N data bytes. Each word is sent LSB first.
- Loader FSM states: `HDR_LO`, `HDR_HI`, `DATA`, `DONE`, `ERR`.
  - `HDR_LO`: the first byte sets N[7:0].
  - `HDR_HI`: the next byte sets N[15:8]. Then:
    - N = 0 → `DONE`.
    - N > `IMEM_DEPTH` → `ERR`.
    - Otherwise → `DATA`.
  - `DATA`: a 2-bit byte index shifts each byte into `imem_wdata[8*i +: 8]`. On the 4th byte, pulse `imem_we`. After the pulse, increment the word counter and reset the byte index to 0. When the word counter reaches N → `DONE`.
  - `DONE`, `ERR`: terminal. All further bytes are ignored. Only `rst` leaves these states.
- `cpu_rst` = 1 in every state except `DONE`. `load_done` = (state == `DONE`). `load_err` = (state == `ERR`).
- UART RX:
  - `uart_rx` passes through a 2-FF synchronizer.
  - A falling edge starts a half-bit count. The line is resampled at that point; if it is high, this is a glitch and RX returns to idle.
  - Then 8 data bits (LSB first) are sampled, each `CLKS_PER_BIT` apart, followed by the stop bit.
  - Stop bit high → one-cycle `rx_valid` with the byte.
  - Stop bit low → byte discarded, `frame_err` set, loader state unchanged.
- Reset values: `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_rst` 1, `load_done` 0, `load_err` 0, `frame_err` 0. FSM in `HDR_LO`, all counters 0, RX idle.

## Timing
- `rx_valid` fires `CLKS_PER_BIT`/2 + 9×`CLKS_PER_BIT` (±2) cycles after the synchronized start edge.
- Write path:
  - `imem_we` rises the cycle after the 4th byte's `rx_valid`. It is high for exactly 1 cycle.
  - `imem_addr` and `imem_wdata` are stable during that cycle.
  - `imem_addr` advances by 4 the cycle after the strobe.
- Release:
  - After the final `imem_we` cycle, the FSM enters `DONE` on the next edge. `cpu_rst` falls on that same edge.
  - The memory write always completes before the core leaves reset.
- `rst` asserted mid-byte or mid-word: all outputs return to reset values immediately and the image restarts from the header. A partially written memory is not cleared.
- A new start bit arriving within the stop-bit sample cycle is not lost. RX re-arms in the same cycle it emits `rx_valid`.

## Structure
- Shared package `boot_pkg`:
  - Loader state enum `boot_state_t`.
  - Constants `HDR_BYTES = 2` and `BYTES_PER_WORD = 4`.
- Sub-module `uart_rx` contains:
  - The synchronizer, bit-timing counter and shift register.
  - Outputs `rx_valid`, `rx_byte[7:0]` and `rx_frame_err`.
  - Parameter `CLKS_PER_BIT`.
- The top level holds the loader FSM, word and byte counters, and the data assembly register.
- `cpu_rst` is driven from a flop, not from combinational logic.

## Test plan
- **Normal load:** N=2, bytes 0x13 00 00 00 / 0x93 00 10 00 → two `imem_we` pulses: addr 0 data 0x00000013, then addr 4 data 0x00100093. `cpu_rst` falls 1 cycle after the second pulse; `load_done` = 1.
- **Empty image:** header 0x00 0x00 → no `imem_we`; `cpu_rst` falls right after the second header byte; `load_done` = 1.
- **Oversize:** `IMEM_DEPTH`=256, header 0x01 0x01 (N=257) → `load_err` = 1, `cpu_rst` stays 1. The following 1028 bytes produce no `imem_we`.
- **Framing error:** the 3rd data byte is sent with stop bit low, then resent correctly → `frame_err` = 1. The word written is the resent byte's value at the correct address.
- **Glitch rejection:** a low pulse of `CLKS_PER_BIT`/4 cycles on an idle line → no `rx_valid`, no state change.
- **Reset mid-load:** `rst` low after 5 data bytes of N=2, then a full N=1 image is sent → `imem_we` addr 0 with the new word; `load_done` = 1; `frame_err` = 0.
